// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the 2-D pooling engine.
package pool_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, EMIT, DONE} pool_state_t;

  typedef enum logic {POOL_MAX, POOL_AVG} pool_mode_e;

  // Number of window positions along one axis.
  function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned seg,
                                          input int unsigned stride, input bit padding);
    return padding ? (in_dim - 1) / stride + 1 : (in_dim - seg) / stride + 1;
  endfunction

endpackage

// File: rtl/pool_accum.sv
// Running max / sum accumulator for one pooling window, fed one element per cycle.
module pool_accum
  import pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned K          = 4,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  en,
  input  logic                  pad,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned LogK = $clog2(K);
  localparam int unsigned SumW = DATA_WIDTH + LogK;

  // Mode is chosen at run time, so the averaging constraint applies to every build.
  if ((K == 0) || ((K & (K - 1)) != 0)) begin : g_k_check
    $error("pool_accum: window size K must be a power of two");
  end

  logic [SumW-1:0]        acc_q, acc_d, ext;
  logic signed [SumW-1:0] sum_shr_s;
  logic [SumW-1:0]        sum_shr_u;
  logic                   greater;

  always_comb begin
    ext     = SIGNED ? SumW'($signed(data)) : SumW'(data);
    greater = SIGNED ? ($signed(data) > $signed(acc_q[DATA_WIDTH-1:0]))
                     : (data > acc_q[DATA_WIDTH-1:0]);
    acc_d   = acc_q;
    if (en) begin
      if (init) begin
        acc_d = ext;
      end else if (mode == POOL_AVG) begin
        acc_d = acc_q + (pad ? '0 : ext);
      end else if (!pad && greater) begin
        acc_d = ext;
      end
    end
    // Result reflects the element arriving this cycle, so EMIT can latch it directly.
    sum_shr_s = $signed(acc_d) >>> LogK;
    sum_shr_u = acc_d >> LogK;
    if (mode == POOL_AVG) begin
      result = SIGNED ? DATA_WIDTH'(sum_shr_s) : DATA_WIDTH'(sum_shr_u);
    end else begin
      result = DATA_WIDTH'(acc_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pool2d_engine.sv
// Multi-channel 2-D max/average pooling engine: streams windows from SRAM, one read per cycle.
module pool2d_engine
  import pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned IN_ROWS     = 5,
  parameter int unsigned IN_COLS     = 5,
  parameter int unsigned SEG_ROWS    = 2,
  parameter int unsigned SEG_COLS    = 2,
  parameter int unsigned STRIDE_ROWS = 2,
  parameter int unsigned STRIDE_COLS = 2,
  parameter bit          PADDING     = 1'b1,
  parameter bit          SIGNED      = 1'b0,
  localparam int unsigned AW = $clog2(CHANNELS * IN_ROWS * IN_COLS),
  localparam int unsigned CW = $clog2(CHANNELS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         in_addr,
  output logic                  in_rd_en,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         out_channel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned K       = SEG_ROWS * SEG_COLS;
  localparam int unsigned OutRows = out_dim(IN_ROWS, SEG_ROWS, STRIDE_ROWS, PADDING);
  localparam int unsigned OutCols = out_dim(IN_COLS, SEG_COLS, STRIDE_COLS, PADDING);

  typedef logic [15:0] cnt_t;
  localparam cnt_t LastCh = cnt_t'(CHANNELS - 1);
  localparam cnt_t LastOr = cnt_t'(OutRows - 1);
  localparam cnt_t LastOc = cnt_t'(OutCols - 1);
  localparam cnt_t LastSr = cnt_t'(SEG_ROWS - 1);
  localparam cnt_t LastSc = cnt_t'(SEG_COLS - 1);

  pool_state_t           state_q;
  pool_mode_e            mode_q;
  cnt_t                  ch_q, or_q, oc_q, sr_q, sc_q;
  cnt_t                  c_ch, c_or, c_oc, c_sr, c_sc;
  int unsigned           c_row, c_col;
  logic                  c_inb;
  logic [AW-1:0]         c_addr;
  logic                  slot_v_q, first_q, pad_q;
  logic                  last_slot, last_win;
  logic [DATA_WIDTH-1:0] acc_result;

  assign last_slot = (sr_q == LastSr) && (sc_q == LastSc);
  assign last_win  = (ch_q == LastCh) && (or_q == LastOr) && (oc_q == LastOc);

  // Coordinates of the slot issued next: first slot of the next window from EMIT,
  // otherwise the next raster slot of the current window.
  always_comb begin
    c_ch = ch_q;
    c_or = or_q;
    c_oc = oc_q;
    c_sr = sr_q;
    c_sc = sc_q;
    if (state_q == EMIT) begin
      c_sr = '0;
      c_sc = '0;
      if (oc_q == LastOc) begin
        c_oc = '0;
        if (or_q == LastOr) begin
          c_or = '0;
          c_ch = ch_q + 1'b1;
        end else begin
          c_or = or_q + 1'b1;
        end
      end else begin
        c_oc = oc_q + 1'b1;
      end
    end else if (sc_q == LastSc) begin
      c_sc = '0;
      c_sr = sr_q + 1'b1;
    end else begin
      c_sc = sc_q + 1'b1;
    end
    c_row  = 32'(c_or) * STRIDE_ROWS + 32'(c_sr);
    c_col  = 32'(c_oc) * STRIDE_COLS + 32'(c_sc);
    c_inb  = (c_row < IN_ROWS) && (c_col < IN_COLS);
    c_addr = AW'(32'(c_ch) * IN_ROWS * IN_COLS + c_row * IN_COLS + c_col);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= POOL_MAX;
      {ch_q, or_q, oc_q, sr_q, sc_q} <= '0;
      slot_v_q    <= 1'b0;
      first_q     <= 1'b0;
      pad_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_addr     <= '0;
      in_rd_en    <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      slot_v_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            mode_q   <= pool_mode_e'(mode);
            {ch_q, or_q, oc_q, sr_q, sc_q} <= '0;
            busy     <= 1'b1;
            in_rd_en <= 1'b1;
            in_addr  <= '0;
          end
        end
        RUN: begin
          // Tag this slot so the accumulator handles its data next cycle.
          slot_v_q <= 1'b1;
          first_q  <= (sr_q == '0) && (sc_q == '0);
          pad_q    <= !in_rd_en;
          if (last_slot) begin
            state_q  <= DRAIN;
            in_rd_en <= 1'b0;
            in_addr  <= '0;
          end else begin
            sr_q     <= c_sr;
            sc_q     <= c_sc;
            in_rd_en <= c_inb;
            in_addr  <= c_inb ? c_addr : '0;
          end
        end
        DRAIN: begin
          state_q     <= EMIT;
          out_valid   <= 1'b1;
          out_data    <= acc_result;
          out_channel <= CW'(ch_q);
          out_last    <= last_win;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (last_win) begin
              state_q <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q  <= RUN;
              ch_q     <= c_ch;
              or_q     <= c_or;
              oc_q     <= c_oc;
              sr_q     <= c_sr;
              sc_q     <= c_sc;
              in_rd_en <= 1'b1;
              in_addr  <= c_addr;
            end
          end
        end
        DONE: begin
          if (!start) begin
            state_q <= IDLE;
            done    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  pool_accum #(
    .DATA_WIDTH(DATA_WIDTH),
    .K         (K),
    .SIGNED    (SIGNED)
  ) u_accum (
    .clk   (clk),
    .rst   (rst),
    .init  (first_q),
    .en    (slot_v_q),
    .pad   (pad_q),
    .mode  (mode_q),
    .data  (in_data),
    .result(acc_result)
  );

endmodule

// File: tb/tb_pool2d_engine.sv
// Directed bench for pool2d_engine across four geometries with hand-computed pooled values.
module tb_pool2d_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] start_v;
  logic       mode_r, ready;

  logic       busy_a, done_a, rd_a, val_a, last_a, ch_a;
  logic [3:0] addr_a;
  logic [7:0] din_a, dout_a;
  logic       busy_b, done_b, rd_b, val_b, last_b, ch_b;
  logic [3:0] addr_b;
  logic [7:0] din_b, dout_b;
  logic       busy_c, done_c, rd_c, val_c, last_c, ch_c;
  logic [4:0] addr_c;
  logic [7:0] din_c, dout_c;
  logic       busy_d, done_d, rd_d, val_d, last_d;
  logic [1:0] ch_d;
  logic [4:0] addr_d;
  logic [7:0] din_d, dout_d;

  // SRAM models: one-cycle read latency.
  always @(posedge clk) begin
    din_a <= 8'(addr_a);
    din_b <= 8'(addr_b) - 8'd8;
    din_c <= 8'(addr_c);
    din_d <= (addr_d < 5'd16) ? 8'(addr_d) : 8'(addr_d) + 8'd84;
  end

  pool2d_engine #(.DATA_WIDTH(8), .CHANNELS(1), .IN_ROWS(4), .IN_COLS(4), .SEG_ROWS(2),
    .SEG_COLS(2), .STRIDE_ROWS(2), .STRIDE_COLS(2), .PADDING(1'b0), .SIGNED(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_r), .busy(busy_a), .done(done_a),
    .in_addr(addr_a), .in_rd_en(rd_a), .in_data(din_a), .out_data(dout_a),
    .out_channel(ch_a), .out_valid(val_a), .out_ready(ready), .out_last(last_a));

  pool2d_engine #(.DATA_WIDTH(8), .CHANNELS(1), .IN_ROWS(4), .IN_COLS(4), .SEG_ROWS(2),
    .SEG_COLS(2), .STRIDE_ROWS(2), .STRIDE_COLS(2), .PADDING(1'b0), .SIGNED(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_r), .busy(busy_b), .done(done_b),
    .in_addr(addr_b), .in_rd_en(rd_b), .in_data(din_b), .out_data(dout_b),
    .out_channel(ch_b), .out_valid(val_b), .out_ready(ready), .out_last(last_b));

  pool2d_engine #(.DATA_WIDTH(8), .CHANNELS(1), .IN_ROWS(5), .IN_COLS(5), .SEG_ROWS(2),
    .SEG_COLS(2), .STRIDE_ROWS(2), .STRIDE_COLS(2), .PADDING(1'b1), .SIGNED(1'b0)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_r), .busy(busy_c), .done(done_c),
    .in_addr(addr_c), .in_rd_en(rd_c), .in_data(din_c), .out_data(dout_c),
    .out_channel(ch_c), .out_valid(val_c), .out_ready(ready), .out_last(last_c));

  pool2d_engine #(.DATA_WIDTH(8), .CHANNELS(2), .IN_ROWS(4), .IN_COLS(4), .SEG_ROWS(2),
    .SEG_COLS(2), .STRIDE_ROWS(2), .STRIDE_COLS(2), .PADDING(1'b0), .SIGNED(1'b0)) dut_d (
    .clk(clk), .rst(rst), .start(start_v[3]), .mode(mode_r), .busy(busy_d), .done(done_d),
    .in_addr(addr_d), .in_rd_en(rd_d), .in_data(din_d), .out_data(dout_d),
    .out_channel(ch_d), .out_valid(val_d), .out_ready(ready), .out_last(last_d));

  int         sel;
  logic       o_valid, o_last, o_rd, o_busy, o_done;
  logic [7:0] o_data, o_addr;
  logic [1:0] o_ch;

  always_comb begin
    {o_valid, o_last, o_rd, o_busy, o_done} = 5'b0;
    o_data = 8'd0;
    o_addr = 8'd0;
    o_ch   = 2'd0;
    case (sel)
      0: begin
        {o_valid, o_last, o_rd, o_busy, o_done} = {val_a, last_a, rd_a, busy_a, done_a};
        o_data = dout_a; o_addr = 8'(addr_a); o_ch = 2'(ch_a);
      end
      1: begin
        {o_valid, o_last, o_rd, o_busy, o_done} = {val_b, last_b, rd_b, busy_b, done_b};
        o_data = dout_b; o_addr = 8'(addr_b); o_ch = 2'(ch_b);
      end
      2: begin
        {o_valid, o_last, o_rd, o_busy, o_done} = {val_c, last_c, rd_c, busy_c, done_c};
        o_data = dout_c; o_addr = 8'(addr_c); o_ch = 2'(ch_c);
      end
      default: begin
        {o_valid, o_last, o_rd, o_busy, o_done} = {val_d, last_d, rd_d, busy_d, done_d};
        o_data = dout_d; o_addr = 8'(addr_d); o_ch = ch_d;
      end
    endcase
  end

  int checks = 0;
  int errors = 0;
  int max_addr;

  logic [7:0] exp_d[16];
  logic [1:0] exp_c[16];

  int a_max[4] = '{5, 7, 13, 15};
  int a_avg[4] = '{2, 4, 10, 12};
  int b_avg[4] = '{-6, -4, 2, 4};
  int b_max[4] = '{-3, -1, 5, 7};
  int c_max[9] = '{6, 8, 9, 16, 18, 19, 21, 23, 24};
  int c_avg[9] = '{3, 5, 3, 13, 15, 8, 10, 11, 6};
  int d_max[8] = '{5, 7, 13, 15, 105, 107, 113, 115};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one full job on DUT s; flips mode mid-run and holds start through DONE.
  task automatic run_job(input int s, input logic m, input int n, input int rd_exp,
                         input int stall_idx);
    int got, cyc, rds, stalls, stall_rd, addr_bad;
    got = 0; cyc = 0; rds = 0; stalls = 0; stall_rd = 0; addr_bad = 0; max_addr = 0;
    sel = s;
    mode_r = m;
    ready = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b1;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) mode_r = ~m;
      if (o_rd) begin
        rds++;
        if (int'(o_addr) > max_addr) max_addr = int'(o_addr);
      end else if (o_addr != 8'd0) begin
        addr_bad++;
      end
      if (o_valid) begin
        if (got == stall_idx && stalls < 5) begin
          ready = 1'b0;
          stalls++;
          if (o_rd) stall_rd++;
          check("stall_data", 32'(o_data), 32'(exp_d[got]));
        end else begin
          ready = 1'b1;
          check("data", 32'(o_data), 32'(exp_d[got]));
          check("chan", 32'(o_ch), 32'(exp_c[got]));
          check("last", 32'(o_last), 32'(got == n - 1));
          got++;
        end
      end
    end
    if (got != n) check("timeout", 32'(got), 32'(n));
    check("reads", 32'(rds), 32'(rd_exp));
    check("addr_idle", 32'(addr_bad), 32'd0);
    if (stall_idx >= 0) begin
      check("stall_cycles", 32'(stalls), 32'd5);
      check("stall_reads", 32'(stall_rd), 32'd0);
    end
    cyc = 0;
    while (!o_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done", 32'(o_done), 32'd1);
    check("busy_done", 32'(o_busy), 32'd0);
    repeat (3) @(negedge clk);
    check("hold_done", 32'({o_done, o_busy}), 32'b10);
    start_v[s] = 1'b0;
    @(negedge clk);
    check("done_clr", 32'({o_done, o_busy}), 32'b00);
  endtask

  task automatic load(input int i, input int d, input int c);
    exp_d[i] = 8'(d);
    exp_c[i] = 2'(c);
  endtask

  initial begin
    int seen, cyc;
    rst = 1'b1;
    start_v = 4'b0;
    mode_r = 1'b0;
    ready = 1'b1;
    sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1 check("reset_outs", 32'({o_busy, o_done, o_valid, o_rd, o_last, o_addr, o_data, o_ch}),
                32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 4; i++) load(i, a_max[i], 0);
    run_job(0, 1'b0, 4, 16, -1);
    for (int i = 0; i < 4; i++) load(i, a_avg[i], 0);
    run_job(0, 1'b1, 4, 16, -1);
    for (int i = 0; i < 4; i++) load(i, b_avg[i], 0);
    run_job(1, 1'b1, 4, 16, -1);
    for (int i = 0; i < 4; i++) load(i, b_max[i], 0);
    run_job(1, 1'b0, 4, 16, -1);
    for (int i = 0; i < 9; i++) load(i, c_max[i], 0);
    run_job(2, 1'b0, 9, 25, -1);
    check("max_addr", 32'(max_addr), 32'd24);
    for (int i = 0; i < 9; i++) load(i, c_avg[i], 0);
    run_job(2, 1'b1, 9, 25, -1);
    for (int i = 0; i < 8; i++) load(i, d_max[i], i / 4);
    run_job(3, 1'b0, 8, 32, 1);

    // Abort during the third window, then confirm a clean restart.
    sel = 0;
    mode_r = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b1;
    seen = 0;
    cyc = 0;
    while (seen < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (o_valid) seen++;
    end
    check("pre_rst_outputs", 32'(seen), 32'd2);
    repeat (2) @(negedge clk);
    check("pre_rst_run", 32'({o_busy, o_rd}), 32'b11);
    rst = 1'b1;
    #1;
    check("rst_busy_done", 32'({o_busy, o_done}), 32'd0);
    check("rst_read", 32'({o_rd, o_addr}), 32'd0);
    check("rst_out", 32'({o_valid, o_last, o_data, o_ch}), 32'd0);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_valid || o_busy || o_rd) seen++;
    end
    check("quiet_after_rst", 32'(seen), 32'd0);
    for (int i = 0; i < 4; i++) load(i, a_max[i], 0);
    run_job(0, 1'b0, 4, 16, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool2d_engine.md
# pool2d_engine

Multi-channel 2-D pooling engine with a runtime max/average mode, signed or unsigned data, and proper padding handling. It reads a channel-planar feature map from input SRAM and accumulates each window on the fly, issuing one read per cycle, so no window buffer is needed. Pooled results leave on a valid/ready stream with channel tag and last marker. It sits between the convolution output SRAM and the dropout/activation stage, and is the parametrised successor of the single-channel max-only pooling block.

## Interface
- DATA_WIDTH, 8: element width.
- CHANNELS, 4: number of planes processed per `start`.
- IN_ROWS, 5: rows of one plane.
- IN_COLS, 5: columns of one plane.
- SEG_ROWS, 2: window rows.
- SEG_COLS, 2: window columns.
- STRIDE_ROWS, 2: vertical stride.
- STRIDE_COLS, 2: horizontal stride.
- PADDING, 1: 0 = valid windows only; 1 = windows may overhang bottom/right edges.
- SIGNED, 0: 1 = two's-complement compare and average.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled only in IDLE.
- mode  in  1  0 = max, 1 = average; latched when `start` is accepted.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE; held until `start` is low.
- in_addr  out  clog2(CHANNELS*IN_ROWS*IN_COLS)  read address; 0 when `in_rd_en` is low.
- in_rd_en  out  1  read strobe.
- in_data  in  DATA_WIDTH  read data, valid one cycle after `in_rd_en`.
- out_data  out  DATA_WIDTH  pooled value.
- out_channel  out  clog2(CHANNELS)+1  channel index of `out_data`.
- out_valid  out  1  output handshake valid.
- out_ready  in  1  output handshake ready.
- out_last  out  1  high with the final output of the final channel.

## Operation
- Output dimensions:
  - PADDING=1: OUT = (IN-1)/STRIDE+1.
  - PADDING=0: OUT = (IN-SEG)/STRIDE+1.
  - K = SEG_ROWS*SEG_COLS; AVG requires K to be a power of two. This is an elaboration-time check.
- Window order: channel outermost, then out_r, then out_c, then seg_r, then seg_c (raster).
- Address: ch*IN_ROWS*IN_COLS + row*IN_COLS + col, with row = out_r*STRIDE_ROWS + seg_r and col = out_c*STRIDE_COLS + seg_c.
- FSM states:
  - IDLE: `start` goes to RUN. Latch `mode`, clear all counters.
  - RUN: one window slot per cycle.
    - In-bounds slot: `in_rd_en` = 1.
    - Out-of-bounds slot: `in_rd_en` = 0; the slot still takes one cycle.
    - After slot K-1, go to DRAIN.
  - DRAIN: accumulate the last element, then go to EMIT.
  - EMIT: `out_valid` = 1. On `out_ready`, go to RUN for the next window, or to DONE after the last window.
  - DONE: `done` = 1. When `start` = 0, go to IDLE.
- Accumulation happens in the cycle after each slot:
  - Max: the first in-bounds element initialises the accumulator; later elements replace it if greater, using a signed compare when SIGNED=1. Padded slots are excluded. Slot (0,0) is always in bounds, so each window has at least one real element.
  - Average: the sum accumulator is DATA_WIDTH+clog2(K) bits wide, sign-extended when SIGNED=1. Padded slots add 0. The result is sum >>> log2(K): arithmetic shift for signed, truncating toward −inf; logical shift otherwise. The divisor always includes padded slots.
- `out_data`, `out_channel` and `out_last` are registered when entering EMIT and are stable while `out_valid` && !`out_ready`.

## Timing
- Reset: state IDLE. Every output is 0, including `busy`, `done`, `out_valid`, `out_last`, `in_rd_en`, `in_addr`, `out_data` and `out_channel`. The accumulator and counters are 0.
- Reset asserted mid-operation aborts immediately. No output is produced after reset deasserts until a new `start`.
- Cycle c = `start` sampled in IDLE. RUN covers c+1..c+K, DRAIN is c+K+1, and the first `out_valid` is at c+K+2.
- Per window with `out_ready` tied high: K+2 cycles.
- `out_valid` never drops without a handshake. `out_ready` seen outside EMIT is ignored.
- `start` held high through DONE does not restart; it must return low first.
- Changes to `mode` while busy are ignored.

## Structure
- Shared package `pool_pkg`:
  - `pool_state_t` (IDLE, RUN, DRAIN, EMIT, DONE).
  - `pool_mode_e` (POOL_MAX, POOL_AVG).
  - The OUT_ROWS/OUT_COLS sizing functions.
- One sub-module, `pool_accum`: the max/sum accumulator. Ports: init, en, pad, mode, data in; result out. Parametrised on DATA_WIDTH, K and SIGNED.
- The top level holds the FSM, the counters and the address generation.
- Target 200–300 lines of RTL in total.

## Test plan
- 4×4 single channel, 2×2 window, stride 2, PADDING=0, unsigned, data = address (0..15):
  - Max → 5, 7, 13, 15; `out_last` on 15.
  - Average → 2, 4, 10, 12.
- Same geometry, SIGNED=1, data = address−8, average mode → −6, −4, 2, 4. Max mode → −3, −1, 5, 7.
- 5×5, PADDING=1, data = address, max mode:
  - Outputs 6, 8, 9, 16, 18, 19, 21, 23, 24.
  - Exactly 25 `in_rd_en` pulses over 36 slots; `in_addr` never exceeds 24.
  - Average at window (2,2) → 24>>2 = 6.
- CHANNELS=2 on the 4×4 case, plane 1 = plane 0 + 100:
  - 8 outputs; `out_channel` reads 0,0,0,0,1,1,1,1.
  - `out_last` high only on the 8th output (115).
- Backpressure: hold `out_ready` low for 5 cycles on output 2. `out_valid` stays high, `out_data` stays 7, and there are no reads during the stall.
- Assert `rst` during RUN of window 3. All outputs are 0 that cycle; state is IDLE. A fresh `start` yields the full sequence again from window 0.
